// File: rtl/mips_pkg.sv
// mips_pkg: datapath width default and the divider FSM state encoding shared by
// the execute-stage multi-cycle units.
package mips_pkg;
    localparam int MIPS_WIDTH = 32;
    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring shift-subtract step.
// The remainder shifted left is WIDTH+1 bits, so the subtract is done one bit wider.
module div_step
    import mips_pkg::*;
#(
    parameter int WIDTH = MIPS_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nx,
    output logic [WIDTH-1:0] quo_nx
);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] trial;
    logic           ge;
    always_comb begin
        sh     = {rem, quo[WIDTH-1]};
        trial  = sh - {1'b0, divisor};
        // with rem < divisor the shifted value stays below 2*divisor, so bit WIDTH is the borrow
        ge     = ~trial[WIDTH];
        rem_nx = ge ? trial[WIDTH-1:0] : sh[WIDTH-1:0];
        quo_nx = {quo[WIDTH-2:0], ge};
    end
endmodule

// File: rtl/divider.sv
// divider: iterative restoring divider for MIPS DIV/DIVU, one quotient bit per cycle;
// hi = remainder, lo = quotient. Signed DIV is built only when DIV_SIGNED_EN is defined.
module divider
    import mips_pkg::*;
#(
    parameter int WIDTH = MIPS_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             DivE,
    input  logic             SignedE,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             completed,
    output logic             div_by_zero
);
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem, quo, dvsr, raw_a;
    logic [WIDTH-1:0] rem_nx, quo_nx, a_mag, b_mag, hi_fix, lo_fix;

`ifdef DIV_SIGNED_EN
    logic neg_q, neg_r;
    assign a_mag  = (SignedE && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
    assign b_mag  = (SignedE && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
    assign lo_fix = neg_q ? -quo : quo;
    assign hi_fix = neg_r ? -rem : rem;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == DIV_IDLE && DivE) begin
            neg_q <= SignedE && (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
            neg_r <= SignedE && SrcAE[WIDTH-1];
        end
    end
`else
    logic unused_signed;
    assign unused_signed = SignedE;
    assign a_mag  = SrcAE;
    assign b_mag  = SrcBE;
    assign lo_fix = quo;
    assign hi_fix = rem;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (dvsr),
        .rem_nx  (rem_nx),
        .quo_nx  (quo_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= DIV_IDLE;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvsr        <= '0;
            raw_a       <= '0;
            hi          <= '0;
            lo          <= '0;
            busy        <= 1'b0;
            completed   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            completed <= 1'b0;
            if (state == DIV_IDLE && DivE) begin
                dvsr        <= b_mag;
                quo         <= a_mag;
                rem         <= '0;
                raw_a       <= SrcAE;
                cnt         <= '0;
                busy        <= 1'b1;
                div_by_zero <= 1'b0;
                state       <= DIV_RUN;
            end else if (state == DIV_RUN) begin
                rem <= rem_nx;
                quo <= quo_nx;
                cnt <= cnt + 1'b1;
                if (cnt == CNT_W'(WIDTH - 1))
                    state <= DIV_DONE;
            end else if (state == DIV_DONE) begin
                // divide by zero runs full length, then the MIPS-visible result is forced
                hi          <= (dvsr == '0) ? raw_a : hi_fix;
                lo          <= (dvsr == '0) ? '1 : lo_fix;
                div_by_zero <= (dvsr == '0);
                completed   <= 1'b1;
                busy        <= 1'b0;
                state       <= DIV_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_divider.sv
// tb_divider: scoreboard bench for divider; expected hi/lo/div_by_zero and completion cycle
// are queued at each start and checked by an independent monitor.
module tb_divider;
    localparam int W = 32;
    localparam int LAT = W + 1;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0, rst = 1'b1, DivE = 1'b0, SignedE = 1'b0;
    logic [W-1:0] SrcAE = '0, SrcBE = '0;
    logic [W-1:0] hi, lo;
    logic         busy, completed, div_by_zero;
    exp_t         q[$];
    int           cyc = 0, n_cmp = 0, n_bad = 0;
    logic [W-1:0] held_hi = '0, held_lo = '0;

    divider #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .SrcAE(SrcAE), .SrcBE(SrcBE), .DivE(DivE), .SignedE(SignedE),
        .hi(hi), .lo(lo), .busy(busy), .completed(completed), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // reference: plain integer division with MIPS divide-by-zero convention
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input int c);
        exp_t   e;
        longint sa, sb;
        e.cyc = c;
        e.dz  = (b == 0);
        if (b == 0) begin
            e.hi = a;
            e.lo = '1;
        end else if (s && SIGNED_EN) begin
            sa   = longint'($signed(a));
            sb   = longint'($signed(b));
            e.lo = 32'(sa / sb);
            e.hi = 32'(sa % sb);
        end else begin
            e.lo = a / b;
            e.hi = a % b;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (completed) begin
                if (q.size() == 0) fail("unexpected completion");
                else begin
                    e = q.pop_front();
                    check("lo", lo, e.lo);
                    check("hi", hi, e.hi);
                    check("div_by_zero", 32'(div_by_zero), 32'(e.dz));
                    check("latency", 32'(cyc), 32'(e.cyc));
                    check("busy at completion", 32'(busy), 32'd0);
                    held_hi = e.hi;
                    held_lo = e.lo;
                end
            end else if (busy) begin
                check("hi held", hi, held_hi);
                check("lo held", lo, held_lo);
            end
        end
    end

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input bit b2b);
        int t = 0;
        while (busy && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (busy) fail("idle wait timeout");
        if (b2b) check("start during completed", 32'(completed), 32'd1);
        SrcAE = a;
        SrcBE = b;
        SignedE = s;
        DivE = 1'b1;
        q.push_back(model(a, b, s, cyc + 1 + LAT));
        @(negedge clk);
        DivE = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset hi", hi, '0);
        check("reset lo", lo, '0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset completed", 32'(completed), 32'd0);
        check("reset div_by_zero", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        start(32'd100, 32'd7, 1'b0, 1'b0);
        start(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        start(32'd5, 32'd0, 1'b0, 1'b0);
        start(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0);
        start(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0);
        start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        start(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b0);

        // a start request mid-run must be dropped, then a back-to-back start during completed
        start(32'd1000, 32'd10, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        check("busy before ignored start", 32'(busy), 32'd1);
        SrcAE = 32'd77; SrcBE = 32'd5; DivE = 1'b1;
        @(negedge clk);
        DivE = 1'b0;
        start(32'd12345, 32'h11, 1'b0, 1'b1);

        // asynchronous reset mid-operation
        start(32'hDEAD_BEEF, 32'd3, 1'b0, 1'b0);
        repeat (14) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst hi", hi, '0);
        check("rst lo", lo, '0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst completed", 32'(completed), 32'd0);
        q.delete();
        held_hi = '0;
        held_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start(32'd9, 32'd3, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] a, b;
            int k;
            a = $urandom;
            k = $urandom_range(0, 9);
            b = (k == 0) ? '0 : (k < 4) ? W'($urandom_range(1, 15)) : W'($urandom);
            start(a, b, 1'($urandom_range(0, 1)), 1'b0);
        end

        for (int t = 0; t < 100 && q.size() != 0; t++) @(negedge clk);
        if (q.size() != 0) fail("drain timeout");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/divider.md
Name: divider

Overview:
- Iterative restoring shift-subtract divider for MIPS DIV/DIVU; the inverse of the shift-add multiplier.
- Sits in the execute stage beside the multiplier and writes the same hi/lo register pair: hi = remainder, lo = quotient.
- Self-contained: owns a 33-bit subtractor and does not borrow the main ALU.
- One quotient bit per cycle; the hazard unit stalls the pipeline on busy.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- SrcAE  input  WIDTH  dividend.
- SrcBE  input  WIDTH  divisor.
- DivE  input  1  start request; sampled only in IDLE.
- SignedE  input  1  1 = DIV (signed), 0 = DIVU; used only with DIV_SIGNED_EN.
- hi  output  WIDTH  remainder, registered.
- lo  output  WIDTH  quotient, registered.
- busy  output  1  high while an operation is in flight.
- completed  output  1  single-cycle pulse when hi/lo have just been updated.
- div_by_zero  output  1  valid with completed; set when the divisor was 0.

Behaviour:
- Reset: hi=0, lo=0, busy=0, completed=0, div_by_zero=0, internal registers 0, state IDLE. Reset mid-operation aborts immediately; hi/lo return to 0.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE, edge N with DivE=1:
  - Latch divisor magnitude, quotient register = dividend magnitude, remainder register = 0, counter=0.
  - Latch sign flags and the raw dividend.
  - busy<=1; go to RUN.
- DivE=0 in IDLE: no state change. DivE in RUN/DONE is ignored; it is not queued.
- RUN, edges N+1..N+WIDTH, one step per edge:
  - {rem,quo} shifted left 1.
  - trial = shifted rem - divisor, computed 33 bits wide.
  - If trial is non-negative: rem<=trial, quo LSB<=1; else rem keeps the shifted value, quo LSB<=0.
  - counter++. After step WIDTH (counter==WIDTH-1 on entry), go to DONE.
- DONE, edge N+WIDTH+1:
  - Write hi/lo with the final, sign-corrected values; completed<=1, busy<=0; go to IDLE.
  - Total latency: completed is high in the cycle after edge N+33 (WIDTH=32). It falls at the next edge unless a new start occurs.
- Back-to-back: DivE may be high in the same cycle completed is high. That start is accepted at the edge completed falls.
- Divide by zero: no early exit; same latency. Result forced to hi = raw SrcAE latched at start, lo = all ones; div_by_zero=1 for that completion.
- div_by_zero is cleared at every accepted start.
- hi/lo hold their previous values from start until DONE.

Optional Feature:
- Macro DIV_SIGNED_EN.
- Defined:
  - With SignedE=1, operands are converted to magnitudes at start.
  - Quotient is negated if the operand signs differ; remainder takes the sign of the dividend.
  - -2^31 / -1 produces lo=0x80000000, hi=0 as the natural wrap, with no exception.
- Undefined: SignedE is ignored and every operation is unsigned. The sign-capture and negation logic is not built.

Decomposition:
- Shared package mips_pkg: WIDTH default and the state encoding constants (DIV_IDLE, DIV_RUN, DIV_DONE). The multiplier may reuse the package.
- One natural sub-module, div_step: combinational single restoring step. Inputs are rem, quo, divisor; outputs are next rem and next quo. Instantiated once.

Test Plan:
- DIVU 100/7: start, then count cycles -> completed at start+34 with lo=14, hi=2, div_by_zero=0, busy low the same cycle.
- DIVU 0xFFFFFFFF/1 -> lo=0xFFFFFFFF, hi=0; and 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1, same latency.
- DIV_SIGNED_EN, SignedE=1:
  - -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - 7/-2 -> lo=-3, hi=1.
  - 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DivE pulsed again at start+10 with different operands -> ignored; the first result is unchanged. Then a back-to-back start asserted during completed -> second result at +34 after acceptance.
- Assert rst at start+15 -> hi/lo/busy/completed 0 immediately. A next divide of 9/3 -> lo=3, hi=0.
- Without DIV_SIGNED_EN: SignedE=1, 0xFFFFFFF9/2 -> unsigned result lo=0x7FFFFFFC, hi=1.
